// File: rtl/midi_encoder_pkg.sv
// Shared MIDI message types, status-type constants and byte-count helper for the
// MIDI transmit path.
package midi_encoder_pkg;

    localparam int unsigned MIDI_BAUD = 31250;

    typedef struct packed {
        logic [3:0] message_type;
        logic [3:0] channel;
        logic [7:0] data_byte1;
        logic [7:0] data_byte2;
    } message_t;

    localparam logic [3:0] NOTE_OFF         = 4'h8;
    localparam logic [3:0] NOTE_ON          = 4'h9;
    localparam logic [3:0] POLY_PRESSURE    = 4'hA;
    localparam logic [3:0] CONTROL_CHANGE   = 4'hB;
    localparam logic [3:0] PROGRAM_CHANGE   = 4'hC;
    localparam logic [3:0] CHANNEL_PRESSURE = 4'hD;
    localparam logic [3:0] PITCH_BEND       = 4'hE;
    localparam logic [3:0] SYSTEM           = 4'hF;

    localparam logic [7:0] DATA_MASK = 8'h7F;

    typedef enum logic [1:0] {StIdle, StStatus, StData1, StData2} tx_state_e;

    function automatic logic [1:0] data_byte_count(input logic [3:0] message_type);
        case (message_type)
            NOTE_OFF, NOTE_ON, POLY_PRESSURE, CONTROL_CHANGE, PITCH_BEND: return 2'd2;
            PROGRAM_CHANGE, CHANNEL_PRESSURE:                             return 2'd1;
            default:                                                      return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/midi_uart_tx.sv
// 8N1 serialiser: start bit, 8 data bits LSB first, stop bit, BIT_CYCLES clocks per bit.
// A start strobe in the done cycle chains the next frame with no idle gap.
module midi_uart_tx #(
    parameter int unsigned BIT_CYCLES = 1600
) (
    input  logic       clock_50_000_000,
    input  logic       reset_l,
    input  logic [7:0] tx_byte,
    input  logic       start,
    output logic       tx,
    output logic       done,
    output logic       busy
);

    localparam int unsigned CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CYCLE = CW'(BIT_CYCLES - 1);

    logic [9:0]    frame_q;
    logic [3:0]    bit_q;
    logic [CW-1:0] cycle_q;
    logic          active_q;
    logic          bit_end;

    assign bit_end = (cycle_q == LAST_CYCLE);
    assign done    = active_q && bit_end && (bit_q == 4'd9);
    assign tx      = frame_q[0];
    assign busy    = active_q;

    // Frame shifts out LSB first and refills with ones, so the line idles high.
    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            frame_q  <= '1;
            bit_q    <= 4'd0;
            cycle_q  <= '0;
            active_q <= 1'b0;
        end else if (start) begin
            frame_q  <= {1'b1, tx_byte, 1'b0};
            bit_q    <= 4'd0;
            cycle_q  <= '0;
            active_q <= 1'b1;
        end else if (active_q) begin
            if (bit_end) begin
                cycle_q <= '0;
                frame_q <= {1'b1, frame_q[9:1]};
                if (bit_q == 4'd9) begin
                    active_q <= 1'b0;
                end else begin
                    bit_q <= bit_q + 4'd1;
                end
            end else begin
                cycle_q <= cycle_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/midi_encoder.sv
// Expands decoded MIDI messages into status/data wire bytes with optional running
// status and streams them back-to-back through the 8N1 serialiser.
module midi_encoder
    import midi_encoder_pkg::*;
#(
    parameter int unsigned CLOCK_HZ       = 50_000_000,
    parameter int unsigned BAUD           = MIDI_BAUD,
    parameter bit          RUNNING_STATUS = 1'b1
) (
    input  logic     clock_50_000_000,
    input  logic     reset_l,
    input  message_t message,
    input  logic     message_valid,
    output logic     message_ready,
    output logic     midi_tx,
    output logic     busy,
    output logic     message_error
);

    localparam int unsigned BIT_CYCLES = CLOCK_HZ / BAUD;

    tx_state_e  state_q, state_d;
    logic [7:0] data1_q, data2_q;
    logic [1:0] count_q;
    logic [7:0] stored_status_q;
    logic       stored_valid_q;
    logic       error_q, error_d;

    logic [7:0] status;
    logic       is_channel;
    logic       skip_status;
    logic       accept;
    logic       tx_start, tx_done;
    logic [7:0] tx_byte;

    assign status        = {message.message_type, message.channel};
    assign is_channel    = message.message_type[3] && (message.message_type != SYSTEM);
    assign skip_status   = RUNNING_STATUS && is_channel && stored_valid_q
                           && (stored_status_q == status);
    assign message_ready = (state_q == StIdle);
    assign accept        = message_valid && message_ready;
    assign message_error = error_q;

    // The first byte starts on the accepting edge so the start bit appears one cycle later.
    always_comb begin
        state_d  = state_q;
        tx_start = 1'b0;
        tx_byte  = 8'h00;
        error_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (message_valid) begin
                    if (!message.message_type[3]) begin
                        error_d = 1'b1;
                    end else begin
                        tx_start = 1'b1;
                        if (skip_status) begin
                            tx_byte = message.data_byte1 & DATA_MASK;
                            state_d = StData1;
                        end else begin
                            tx_byte = status;
                            state_d = StStatus;
                        end
                    end
                end
            end
            StStatus: begin
                if (tx_done) begin
                    if (count_q != 2'd0) begin
                        tx_start = 1'b1;
                        tx_byte  = data1_q;
                        state_d  = StData1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StData1: begin
                if (tx_done) begin
                    if (count_q == 2'd2) begin
                        tx_start = 1'b1;
                        tx_byte  = data2_q;
                        state_d  = StData2;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StData2: begin
                if (tx_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            state_q         <= StIdle;
            data1_q         <= 8'h00;
            data2_q         <= 8'h00;
            count_q         <= 2'd0;
            stored_status_q <= 8'h00;
            stored_valid_q  <= 1'b0;
            error_q         <= 1'b0;
        end else begin
            state_q <= state_d;
            error_q <= error_d;
            if (accept && message.message_type[3]) begin
                data1_q <= message.data_byte1 & DATA_MASK;
                data2_q <= message.data_byte2 & DATA_MASK;
                count_q <= data_byte_count(message.message_type);
                // Real-time messages (0xF8-0xFF) leave the running status untouched.
                if (is_channel) begin
                    stored_status_q <= status;
                    stored_valid_q  <= 1'b1;
                end else if (!message.channel[3]) begin
                    stored_valid_q <= 1'b0;
                end
            end
        end
    end

    midi_uart_tx #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_uart_tx (
        .clock_50_000_000(clock_50_000_000),
        .reset_l         (reset_l),
        .tx_byte         (tx_byte),
        .start           (tx_start),
        .tx              (midi_tx),
        .done            (tx_done),
        .busy            (busy)
    );

endmodule

// File: tb/tb_midi_encoder.sv
// Directed bench for midi_encoder: decodes the serial line bit by bit and compares the
// byte stream and handshake timing against hand-computed values.
module tb_midi_encoder;
    import midi_encoder_pkg::*;

    localparam int unsigned CLK_HZ = 312_500;
    localparam int unsigned BC     = 10;

    logic     clk = 1'b0;
    logic     reset_l;
    message_t message;
    logic     valid, valid0;
    logic     ready, tx, busy, err;
    logic     ready0, tx0, busy0, err0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    midi_encoder #(
        .CLOCK_HZ      (CLK_HZ),
        .BAUD          (31250),
        .RUNNING_STATUS(1'b1)
    ) dut (
        .clock_50_000_000(clk),
        .reset_l         (reset_l),
        .message         (message),
        .message_valid   (valid),
        .message_ready   (ready),
        .midi_tx         (tx),
        .busy            (busy),
        .message_error   (err)
    );

    midi_encoder #(
        .CLOCK_HZ      (CLK_HZ),
        .BAUD          (31250),
        .RUNNING_STATUS(1'b0)
    ) dut_nors (
        .clock_50_000_000(clk),
        .reset_l         (reset_l),
        .message         (message),
        .message_valid   (valid0),
        .message_ready   (ready0),
        .midi_tx         (tx0),
        .busy            (busy0),
        .message_error   (err0)
    );

    function automatic message_t mk(input logic [3:0] t, input logic [3:0] c,
                                    input logic [7:0] d1, input logic [7:0] d2);
        message_t m;
        m.message_type = t;
        m.channel      = c;
        m.data_byte1   = d1;
        m.data_byte2   = d2;
        return m;
    endfunction

    // Called in the first cycle of a start bit (#1 after the edge); returns in the
    // first cycle after the stop bit.
    task automatic recv_frame(input bit sel, output logic [7:0] b, output logic sb,
                              output logic pb);
        b  = 8'h00;
        sb = sel ? tx0 : tx;
        for (int i = 0; i < 8; i++) begin
            repeat (BC) @(posedge clk);
            #1;
            b[i] = sel ? tx0 : tx;
        end
        repeat (BC) @(posedge clk);
        #1;
        pb = sel ? tx0 : tx;
        repeat (BC) @(posedge clk);
        #1;
    endtask

    task automatic xfer(input bit sel, input message_t m, input int n, output logic [23:0] got,
                        output logic acc_ok, output logic frame_ok, output logic end_ok);
        logic [7:0] b;
        logic       sb, pb;
        got      = 24'h0;
        acc_ok   = 1'b0;
        frame_ok = 1'b1;
        end_ok   = 1'b0;
        for (int i = 0; i < 2000 && !acc_ok; i++) begin
            if ((sel ? ready0 : ready) === 1'b1) acc_ok = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!acc_ok) return;
        message = m;
        if (sel) valid0 = 1'b1;
        else valid = 1'b1;
        @(posedge clk);
        #1;
        valid  = 1'b0;
        valid0 = 1'b0;
        if ((sel ? ready0 : ready) !== 1'b0 || (sel ? busy0 : busy) !== 1'b1) frame_ok = 1'b0;
        for (int k = 0; k < n; k++) begin
            recv_frame(sel, b, sb, pb);
            got = {got[15:0], b};
            if (sb !== 1'b0 || pb !== 1'b1) frame_ok = 1'b0;
        end
        end_ok = sel ? (ready0 === 1'b1 && busy0 === 1'b0 && tx0 === 1'b1)
                     : (ready === 1'b1 && busy === 1'b0 && tx === 1'b1);
    endtask

    task automatic test_reset();
        reset_l = 1'b0;
        valid   = 1'b0;
        valid0  = 1'b0;
        message = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({tx, ready, busy, err} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_state got tx/ready/busy/err=%b want 1100",
                     {tx, ready, busy, err});
        end
        checks++;
        if ({tx0, ready0, busy0, err0} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_state_nors got %b want 1100", {tx0, ready0, busy0, err0});
        end
        reset_l = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_note_on();
        logic [23:0] got;
        logic        a, f, e;
        xfer(1'b0, mk(NOTE_ON, 4'h0, 8'd60, 8'd100), 3, got, a, f, e);
        checks++;
        if (got !== 24'h903C64 || !a || !f || !e) begin
            errors++;
            $display("FAIL note_on got %h acc%b frm%b end%b want 903C64 111", got, a, f, e);
        end
    endtask

    task automatic test_running_status();
        logic [23:0] got;
        logic        a, f, e;
        xfer(1'b0, mk(NOTE_ON, 4'h0, 8'd62, 8'd0), 2, got, a, f, e);
        checks++;
        if (got !== 24'h003E00 || !a || !f || !e) begin
            errors++;
            $display("FAIL running_status got %h acc%b frm%b end%b want 003E00 111", got, a, f, e);
        end
        xfer(1'b1, mk(NOTE_ON, 4'h0, 8'd60, 8'd100), 3, got, a, f, e);
        checks++;
        if (got !== 24'h903C64 || !a || !f || !e) begin
            errors++;
            $display("FAIL nors_first got %h acc%b frm%b end%b want 903C64 111", got, a, f, e);
        end
        xfer(1'b1, mk(NOTE_ON, 4'h0, 8'd62, 8'd0), 3, got, a, f, e);
        checks++;
        if (got !== 24'h903E00 || !a || !f || !e) begin
            errors++;
            $display("FAIL nors_resend got %h acc%b frm%b end%b want 903E00 111", got, a, f, e);
        end
    endtask

    task automatic test_program_change();
        logic [23:0] got;
        logic        a, f, e;
        xfer(1'b0, mk(PROGRAM_CHANGE, 4'h3, 8'hA5, 8'h55), 2, got, a, f, e);
        checks++;
        if (got !== 24'h00C325 || !a || !f || !e) begin
            errors++;
            $display("FAIL program_change got %h acc%b frm%b end%b want 00C325 111",
                     got, a, f, e);
        end
    endtask

    task automatic test_system();
        logic [23:0] got;
        logic        a, f, e;
        xfer(1'b0, mk(NOTE_ON, 4'h0, 8'd60, 8'd100), 3, got, a, f, e);
        checks++;
        if (got !== 24'h903C64 || !a || !f || !e) begin
            errors++;
            $display("FAIL status_change got %h want 903C64 (acc%b frm%b end%b)", got, a, f, e);
        end
        xfer(1'b0, mk(SYSTEM, 4'h8, 8'h11, 8'h22), 1, got, a, f, e);
        checks++;
        if (got !== 24'h0000F8 || !a || !f || !e) begin
            errors++;
            $display("FAIL realtime_f8 got %h want 0000F8 (acc%b frm%b end%b)", got, a, f, e);
        end
        xfer(1'b0, mk(NOTE_ON, 4'h0, 8'd62, 8'd0), 2, got, a, f, e);
        checks++;
        if (got !== 24'h003E00 || !a || !f || !e) begin
            errors++;
            $display("FAIL rs_after_rt got %h want 003E00 (acc%b frm%b end%b)", got, a, f, e);
        end
        xfer(1'b0, mk(SYSTEM, 4'h2, 8'h11, 8'h22), 1, got, a, f, e);
        checks++;
        if (got !== 24'h0000F2 || !a || !f || !e) begin
            errors++;
            $display("FAIL common_f2 got %h want 0000F2 (acc%b frm%b end%b)", got, a, f, e);
        end
        xfer(1'b0, mk(NOTE_ON, 4'h0, 8'd62, 8'd0), 3, got, a, f, e);
        checks++;
        if (got !== 24'h903E00 || !a || !f || !e) begin
            errors++;
            $display("FAIL rs_after_f2 got %h want 903E00 (acc%b frm%b end%b)", got, a, f, e);
        end
    endtask

    // Second message is held valid while busy and must start right after ready rises.
    task automatic test_back_to_back();
        logic [7:0] b;
        logic       sb, pb;
        logic [23:0] got;
        message = mk(SYSTEM, 4'h8, 8'h00, 8'h00);
        valid   = 1'b1;
        @(posedge clk);
        #1;
        message = mk(NOTE_ON, 4'h1, 8'h40, 8'h7F);
        recv_frame(1'b0, b, sb, pb);
        checks++;
        if (b !== 8'hF8 || sb !== 1'b0 || pb !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first got %h start%b stop%b want F8 0 1", b, sb, pb);
        end
        checks++;
        if (ready !== 1'b1 || tx !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready got ready%b tx%b want 1 1", ready, tx);
        end
        @(posedge clk);
        #1;
        valid = 1'b0;
        checks++;
        if (tx !== 1'b0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_start got tx%b ready%b want 0 0", tx, ready);
        end
        got = 24'h0;
        for (int k = 0; k < 3; k++) begin
            recv_frame(1'b0, b, sb, pb);
            got = {got[15:0], b};
        end
        checks++;
        if (got !== 24'h91407F || ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second got %h ready%b want 91407F 1", got, ready);
        end
    endtask

    task automatic test_drop();
        message = mk(4'h3, 4'h0, 8'h12, 8'h34);
        valid   = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        checks++;
        if ({err, tx, ready, busy} !== 4'b1110) begin
            errors++;
            $display("FAIL drop_pulse got err/tx/ready/busy=%b want 1110", {err, tx, ready, busy});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({err, tx, ready} !== 3'b011) begin
            errors++;
            $display("FAIL drop_end got err/tx/ready=%b want 011", {err, tx, ready});
        end
    endtask

    task automatic test_reset_mid();
        logic [23:0] got;
        logic        a, f, e;
        message = mk(NOTE_ON, 4'h0, 8'h40, 8'h10);
        valid   = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        repeat (BC * 15) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || ready !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset got busy%b ready%b want 1 0", busy, ready);
        end
        #2 reset_l = 1'b0;
        #1;
        checks++;
        if ({tx, ready, busy} !== 3'b110) begin
            errors++;
            $display("FAIL mid_reset got tx/ready/busy=%b want 110", {tx, ready, busy});
        end
        @(posedge clk);
        #1;
        reset_l = 1'b1;
        xfer(1'b0, mk(NOTE_ON, 4'h0, 8'h40, 8'h10), 3, got, a, f, e);
        checks++;
        if (got !== 24'h904010 || !a || !f || !e) begin
            errors++;
            $display("FAIL post_reset got %h want 904010 (acc%b frm%b end%b)", got, a, f, e);
        end
    endtask

    initial begin
        test_reset();
        test_note_on();
        test_running_status();
        test_program_change();
        test_system();
        test_back_to_back();
        test_drop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/midi_encoder.md
Name: midi_encoder

Overview:
- Transmit-side counterpart of the MIDI input path: accepts decoded MIDI messages and re-serialises them as MIDI wire bytes on a UART line (31250 baud, 8N1).
- Used for MIDI THRU/OUT: echoes or forwards messages from the synth core.
- Each message is expanded into status byte plus 0–2 data bytes.
- Running status (omitting a repeated status byte) is applied optionally.

Parameters:
- CLOCK_HZ, 50_000_000, system clock frequency.
- BAUD, 31250, MIDI bit rate. BIT_CYCLES = CLOCK_HZ/BAUD (1600 at defaults).
- RUNNING_STATUS, 1, when 1 a channel status byte identical to the last one sent is omitted.

Ports:
- clock_50_000_000  input  1  system clock.
- reset_l  input  1  asynchronous, active-low reset.
- message  input  MIDI::message_t  fields used: message_type[3:0], channel[3:0], data_byte1[7:0], data_byte2[7:0].
- message_valid  input  1  message present this cycle.
- message_ready  output  1  block can accept a message; transfer when valid&&ready.
- midi_tx  output  1  serial line, idle high.
- busy  output  1  high while any byte is being shifted.
- message_error  output  1  one-cycle pulse when a message is dropped.

Behaviour:
- Clocking and reset:
  - One clock domain (clock_50_000_000). Reset is asynchronous and active-low (reset_l).
  - Reset values: midi_tx=1, message_ready=1, busy=0, message_error=0. Running-status register is cleared (invalid). FSM=IDLE.
  - Reset mid-byte aborts immediately; the line returns high with no partial stop bit.
- Byte expansion (status = {message_type, channel}):
  - types 0x8, 0x9, 0xA, 0xB, 0xE: 3 bytes (status, data_byte1, data_byte2).
  - types 0xC, 0xD: 2 bytes (status, data_byte1).
  - type 0xF: 1 byte (status only, channel field = low nibble).
  - type <0x8: message dropped; message_error pulses in the cycle after acceptance; message_ready stays high.
  - Data bytes are transmitted with bit 7 forced to 0.
- Running status (RUNNING_STATUS=1):
  - Types 0x8–0xE: status byte skipped if equal to the stored status; otherwise sent and stored.
  - 0xF0–0xF7: sent, and stored status cleared.
  - 0xF8–0xFF (real-time): sent, stored status unchanged.
- FSM states, one byte per state:
  - IDLE: message_ready=1. On valid&&ready, latch the message and go to the first byte required: STATUS, or DATA1 if the status byte is skipped.
  - STATUS → DATA1 → DATA2 → IDLE; states not needed for the message type are skipped.
  - message_ready=0 in all non-IDLE states.
  - Each byte state starts the serialiser and waits for its done pulse.
- Serialiser framing:
  - Start bit 0, 8 data bits LSB first, stop bit 1; each bit lasts exactly BIT_CYCLES cycles.
  - Bit counter 0..9; cycle counter 0..BIT_CYCLES-1 wraps per bit.
- Timing:
  - Acceptance at cycle T: midi_tx goes low at T+1.
  - Consecutive bytes are back-to-back: the next start bit immediately follows the previous stop bit, with no idle cycles.
  - busy=1 from T+1 through the last stop-bit cycle.
  - message_ready=1 the cycle after the final stop bit ends.
  - Total latency = bytes × 10 × BIT_CYCLES.
- Boundary conditions:
  - message_valid while not ready: the input is ignored and must be held by the producer.
  - A new message can be accepted on the same cycle message_ready rises; its start bit then follows with no gap.

Decomposition:
- MIDI package (shared):
  - message_t.
  - Status type constants NOTE_OFF=0x8 … PITCH_BEND=0xE, SYSTEM=0xF.
  - Function data_byte_count(message_type) returning 0/1/2.
- CONFIG package: MIDI_BAUD=31250.
- Sub-module midi_uart_tx:
  - byte in, start strobe, tx, done pulse, BIT_CYCLES parameter.
  - Pure 8N1 serialiser.
  - Reusable and separately testable.

Test Plan:
- Note-on 0x9/ch0/60/100 from reset → bytes 0x90,0x3C,0x64. midi_tx low at T+1 for 1600 cycles; total 48000 cycles; message_ready back at T+48001.
- Second note-on ch0 (62,0) with RUNNING_STATUS=1 → only 0x3E,0x00 sent (32000 cycles). Same stimulus with RUNNING_STATUS=0 → 0x90 resent.
- Program change 0xC/ch3/data 0xA5 → bytes 0xC3,0x25 (bit 7 masked).
- Clock 0xF/0x8 between two ch0 note-ons → 0x90,x,y,0xF8,x,y: running status preserved. 0xF/0x2 between them → status 0x90 resent.
- message_type 0x3 → message_error pulse at T+1, midi_tx stays high, message_ready stays 1.
- reset_l low at bit 4 of byte 2 → midi_tx=1 and message_ready=1 immediately. Next 0x9/ch0 message resends status 0x90.
